fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the combinational forwarding control.
- Keeps a shift-register scoreboard of in-flight register writers, one entry per pipeline stage from EX onward.
- Resolves operand sources for the instruction in ID, for any number of source operands, from any stage depth.
- Raises a load-use stall when the producer's data will not be forwardable in time.
- Sits beside the ID/EX pipeline register. Drives the EX forwarding MUX selects and the ID/IF stall.

Parameters:
- NUM_REGS, 32: architectural registers; register 0 is hard-wired zero. RW = $clog2(NUM_REGS).
- NUM_SRC, 2: source operands queried per cycle.
- DEPTH, 3: tracked stages. Entry 0 = EX, 1 = MEM, ..., DEPTH-1 = WB. Minimum 2.
- LOAD_READY, 2: stage position at which load data becomes forwardable (1 <= LOAD_READY <= DEPTH-1).
- SW = $clog2(DEPTH): forward select width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- hold  in  1  downstream freeze (cache miss); scoreboard does not advance
- flush  in  1  squash the instruction in ID (branch or jump redirect)
- issue_valid  in  1  the ID instruction requests to advance into EX
- issue_kind  in  2  0 = no register write, 1 = ALU/LUI/JAL class, 2 = load, 3 = treated as load
- issue_rd  in  RW  destination register
- src_used  in  NUM_SRC  per-source valid mask
- src_rs  in  NUM_SRC*RW  source register IDs; source k occupies bits [k*RW +: RW]
- fwd_sel  out  NUM_SRC*SW  per source: 0 = regfile, p = forward from stage position p (1 = MEM, ..., DEPTH-1 = WB)
- stall  out  1  ID instruction must not advance this cycle
- occupancy  out  $clog2(DEPTH+1)  count of valid entries

Behaviour:
- Entry fields: valid, rd, rdy_stage.
- Reset (rst low, asynchronous): all entries invalid. fwd_sel=0, stall=0, occupancy=0.
- Query (combinational), per source k:
  - Ignored, with fwd_sel=0, if src_used[k]=0 or src_rs=0.
  - Otherwise search for the youngest valid entry i (lowest index) with rd==src_rs.
  - No match, or match at i=DEPTH-1 (written to the regfile this edge): fwd_sel=0.
  - Match at i<=DEPTH-2: p=i+1. If p>=rdy_stage, fwd_sel=p. Otherwise the source is "blocked" and fwd_sel=0.
- stall = issue_valid & any source blocked & !flush.
- Update at rising clk edge when hold=0:
  - Entries shift: e[i] <= e[i-1] for i>=1.
  - e[0] <= new entry if issue_valid & !stall & !flush & issue_kind!=0 & issue_rd!=0. Otherwise e[0] <= bubble (invalid).
  - New entry rdy_stage: 1 for kind 1; LOAD_READY for kinds 2/3.
- hold=1: no state change, and issue is ignored. The query still evaluates against frozen state. hold has priority over flush; the pipeline keeps flush asserted until a non-hold cycle.
- Multiple entries with the same rd: the youngest wins (double-hazard rule).
- occupancy is registered and updated on the same edge as the entries.
- Latency: an issued instruction's entry is visible to the query one cycle after issue.
- Load-use with LOAD_READY=2: exactly one stall cycle.

Optional Feature:
- Macro: FWD_SB_STATS_EN.
- When defined, adds two outputs:
  - stat_stalls (32): counts cycles with stall=1 and hold=0.
  - stat_fwds (32): counts accepted issues with any nonzero fwd_sel.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ALU x5 issued, next cycle src_rs[0]=5, used → fwd_sel[0]=1, stall=0. One cycle later with no new issue, querying x5 → fwd_sel=2.
- Load x6 issued, next cycle ID queries x6 → stall=1 for one cycle (e[0] becomes a bubble), then fwd_sel=2, stall=0.
- ALU x7, then ALU x7 again, then a consumer of x7 → fwd_sel=1 (youngest wins), never 2.
- Load x8 followed by a consumer of x8 with hold=1 for 3 cycles → state frozen, stall stays 1. After hold falls: one more stall cycle, then fwd_sel=2.
- Writers to x0, kind 0, or src_used=0 → no entry is tracked and fwd_sel=0. A flush with issue_valid=1 inserts a bubble: occupancy does not increase.
- Assert rst low mid-load-use stall → stall=0 and occupancy=0 immediately. With FWD_SB_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Forwarding scoreboard bus: issue/query request from the ID stage and the
// resulting forward selects, stall and occupancy back to the pipeline.
// Parameters must match the ones given to fwd_scoreboard.
interface fwd_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int SW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic                  hold;
  logic                  flush;
  logic                  issue_valid;
  logic [1:0]            issue_kind;
  logic [RW-1:0]         issue_rd;
  logic [NUM_SRC-1:0]    src_used;
  logic [NUM_SRC*RW-1:0] src_rs;
  logic [NUM_SRC*SW-1:0] fwd_sel;
  logic                  stall;
  logic [OW-1:0]         occupancy;

  // Pipeline side: drives the ID instruction, consumes selects and stall.
  modport master (
    output hold, flush, issue_valid, issue_kind, issue_rd, src_used, src_rs,
    input  fwd_sel, stall, occupancy
  );

  // Scoreboard side.
  modport slave (
    input  hold, flush, issue_valid, issue_kind, issue_rd, src_used, src_rs,
    output fwd_sel, stall, occupancy
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shift register of in-flight register writers, one
// entry per stage from EX (entry 0) to WB (entry DEPTH-1). Resolves the
// forward source of every ID operand and raises a load-use stall when the
// producer's data is not yet forwardable.
// Optional: define FWD_SB_STATS_EN to add saturating stat_stalls/stat_fwds.
module fwd_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2
) (
  input  logic              clk,
  input  logic              rst,
  fwd_scoreboard_if.slave   bus
`ifdef FWD_SB_STATS_EN
  ,
  output logic [31:0]       stat_stalls,
  output logic [31:0]       stat_fwds
`endif
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int SW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_ALU   = 2'd1,
    KIND_LOAD  = 2'd2,
    KIND_LOAD3 = 2'd3
  } kind_e;

  // rdy_stage: first stage position from which the result can be forwarded.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [SW-1:0] rdy_stage;
  } entry_t;

  entry_t                sb_q [DEPTH];
  entry_t                sb_d [DEPTH];
  logic [OW-1:0]         occ_q;
  logic [OW-1:0]         occ_d;
  logic [NUM_SRC-1:0]    blocked;
  logic [NUM_SRC*SW-1:0] fwd_sel_c;
  logic                  stall_c;

  // Per-source lookup: youngest matching writer decides the forward source.
  always_comb begin
    logic [RW-1:0] rs;
    logic          hit;
    logic [SW-1:0] hit_pos;
    logic [SW-1:0] hit_rdy;
    logic [SW-1:0] pos;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    blocked   = '0;
    fwd_sel_c = '0;
    rs        = '0;
    hit       = 1'b0;
    hit_pos   = '0;
    hit_rdy   = '0;
    pos       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs      = bus.src_rs[k*RW +: RW];
      hit     = 1'b0;
      hit_pos = '0;
      hit_rdy = '0;
      // Scan oldest to youngest so the lowest index overrides older matches.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (sb_q[i].valid && sb_q[i].rd == rs) begin
          hit     = 1'b1;
          hit_pos = SW'(i);
          hit_rdy = sb_q[i].rdy_stage;
        end
      end
      pos = hit_pos + SW'(1);
      // A WB match is written to the regfile this edge, so read the regfile.
      if (bus.src_used[k] && rs != '0 && hit && hit_pos != SW'(DEPTH - 1)) begin
        if (pos >= hit_rdy) fwd_sel_c[k*SW +: SW] = pos;
        else                blocked[k] = 1'b1;
      end
    end
  end

  assign stall_c       = bus.issue_valid & (|blocked) & ~bus.flush;
  assign bus.stall     = stall_c;
  assign bus.fwd_sel   = fwd_sel_c;
  assign bus.occupancy = occ_q;

  // Next scoreboard contents: shift by one stage, insert the issuing writer or a bubble.
  always_comb begin
    occ_d           = '0;
    sb_d[0].valid   = bus.issue_valid & ~stall_c & ~bus.flush &
                      (bus.issue_kind != KIND_NONE) & (bus.issue_rd != '0);
    sb_d[0].rd      = bus.issue_rd;
    sb_d[0].rdy_stage = (bus.issue_kind == KIND_ALU) ? SW'(1) : SW'(LOAD_READY);
    for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OW'(sb_d[i].valid);
  end

  // Scoreboard register: advances unless the downstream pipeline holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the entry array is a handful of flops whose valid bits must start clear, so it is reset.
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      occ_q <= '0;
    end else if (!bus.hold) begin
      // NOTE: sequential state uses non-blocking assignments only.
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
      occ_q <= occ_d;
    end
  end

`ifdef FWD_SB_STATS_EN
  logic issue_accept;
  assign issue_accept = bus.issue_valid & ~stall_c & ~bus.flush & ~bus.hold;

  // Saturating event counters: real stall cycles and issues that used forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stalls <= '0;
      stat_fwds   <= '0;
    end else begin
      if (stall_c && !bus.hold && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
      if (issue_accept && (|fwd_sel_c) && stat_fwds != '1) stat_fwds <= stat_fwds + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with default parameters
// (32 regs, 2 sources, DEPTH 3, LOAD_READY 2). fwd_sel packs source 0 in
// bits [1:0] and source 1 in bits [3:2].
module tb_fwd_scoreboard;
  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 3;
  localparam int RW       = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fwd_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

`ifdef FWD_SB_STATS_EN
  logic [31:0] stat_stalls;
  logic [31:0] stat_fwds;
`endif

  fwd_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_READY(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef FWD_SB_STATS_EN
    ,
    .stat_stalls(stat_stalls),
    .stat_fwds  (stat_fwds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.hold        = 1'b0;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_kind  = 2'd0;
    bus.issue_rd    = '0;
    bus.src_used    = '0;
    bus.src_rs      = '0;
  endtask

  task automatic issue(input logic v, input logic [1:0] kind, input logic [RW-1:0] rd);
    bus.issue_valid = v;
    bus.issue_kind  = kind;
    bus.issue_rd    = rd;
  endtask

  task automatic src(input int k, input logic used, input logic [RW-1:0] rs);
    bus.src_used[k]       = used;
    bus.src_rs[k*RW +: RW] = rs;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH) next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b0;
    #1;
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_occ", 32'(bus.occupancy), 32'd0);
    check("reset_fwd", 32'(bus.fwd_sel), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    // ALU x5: forward from MEM next cycle, from WB after that, regfile once retired.
    issue(1'b1, 2'd1, 5'd5);
    settle();
    check("alu_issue_stall", 32'(bus.stall), 32'd0);
    next_cycle();
    idle();
    src(0, 1'b1, 5'd5);
    settle();
    check("alu_fwd_mem", 32'(bus.fwd_sel), 32'h1);
    check("alu_no_stall", 32'(bus.stall), 32'd0);
    check("alu_occ", 32'(bus.occupancy), 32'd1);
    next_cycle();
    settle();
    check("alu_fwd_wb", 32'(bus.fwd_sel), 32'h2);
    next_cycle();
    settle();
    check("alu_retired", 32'(bus.fwd_sel), 32'h0);
    drain();

    // Load x6 followed by a consumer: one stall cycle, then forward from WB.
    issue(1'b1, 2'd2, 5'd6);
    next_cycle();
    issue(1'b1, 2'd1, 5'd9);
    src(0, 1'b1, 5'd6);
    settle();
    check("lu_stall", 32'(bus.stall), 32'd1);
    check("lu_stall_fwd", 32'(bus.fwd_sel), 32'h0);
    next_cycle();
    settle();
    check("lu_release", 32'(bus.stall), 32'd0);
    check("lu_fwd_wb", 32'(bus.fwd_sel), 32'h2);
    next_cycle();
    idle();
    settle();
    check("lu_occ", 32'(bus.occupancy), 32'd2);
    drain();

    // Double hazard on x7: the youngest writer wins.
    issue(1'b1, 2'd1, 5'd7);
    next_cycle();
    issue(1'b1, 2'd1, 5'd7);
    src(1, 1'b1, 5'd7);
    settle();
    check("dh_first", 32'(bus.fwd_sel), 32'h4);
    next_cycle();
    idle();
    src(0, 1'b1, 5'd7);
    src(1, 1'b1, 5'd7);
    settle();
    check("dh_youngest", 32'(bus.fwd_sel), 32'h5);
    next_cycle();
    settle();
    check("dh_next", 32'(bus.fwd_sel), 32'hA);
    drain();

    // Load x8 with hold for 3 cycles: frozen, then one more stall.
    issue(1'b1, 2'd2, 5'd8);
    next_cycle();
    issue(1'b1, 2'd1, 5'd15);
    src(0, 1'b1, 5'd8);
    bus.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("hold_stall", 32'(bus.stall), 32'd1);
      check("hold_occ", 32'(bus.occupancy), 32'd1);
      next_cycle();
    end
    bus.hold = 1'b0;
    settle();
    check("hold_after_stall", 32'(bus.stall), 32'd1);
    next_cycle();
    settle();
    check("hold_release", 32'(bus.stall), 32'd0);
    check("hold_fwd_wb", 32'(bus.fwd_sel), 32'h2);
    next_cycle();
    drain();
`ifdef FWD_SB_STATS_EN
    check("stat_stalls", stat_stalls, 32'd2);
    check("stat_fwds", stat_fwds, 32'd3);
`endif

    // Non-tracked writes: x0, kind 0, flushed issue.
    issue(1'b1, 2'd1, 5'd0);
    next_cycle();
    idle();
    settle();
    check("x0_occ", 32'(bus.occupancy), 32'd0);
    issue(1'b1, 2'd0, 5'd10);
    next_cycle();
    idle();
    src(0, 1'b1, 5'd10);
    settle();
    check("kind0_occ", 32'(bus.occupancy), 32'd0);
    check("kind0_fwd", 32'(bus.fwd_sel), 32'h0);
    issue(1'b1, 2'd1, 5'd11);
    bus.flush = 1'b1;
    next_cycle();
    idle();
    src(0, 1'b1, 5'd11);
    settle();
    check("flush_occ", 32'(bus.occupancy), 32'd0);
    check("flush_fwd", 32'(bus.fwd_sel), 32'h0);
    issue(1'b1, 2'd1, 5'd12);
    next_cycle();
    idle();
    src(0, 1'b0, 5'd12);
    src(1, 1'b1, 5'd12);
    settle();
    check("unused_src", 32'(bus.fwd_sel), 32'h4);
    check("unused_occ", 32'(bus.occupancy), 32'd1);
    drain();

    // Flush suppresses the load-use stall and inserts a bubble.
    issue(1'b1, 2'd2, 5'd13);
    next_cycle();
    issue(1'b1, 2'd1, 5'd16);
    src(0, 1'b1, 5'd13);
    bus.flush = 1'b1;
    settle();
    check("flush_nostall", 32'(bus.stall), 32'd0);
    check("flush_blocked_fwd", 32'(bus.fwd_sel), 32'h0);
    next_cycle();
    idle();
    settle();
    check("flush_bubble_occ", 32'(bus.occupancy), 32'd1);
    drain();

    // Asynchronous reset in the middle of a load-use stall.
    issue(1'b1, 2'd2, 5'd14);
    next_cycle();
    issue(1'b1, 2'd1, 5'd17);
    src(0, 1'b1, 5'd14);
    settle();
    check("rst_pre_stall", 32'(bus.stall), 32'd1);
    check("rst_pre_occ", 32'(bus.occupancy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
`ifdef FWD_SB_STATS_EN
    check("rst_stat_stalls", stat_stalls, 32'd0);
    check("rst_stat_fwds", stat_fwds, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    idle();
    next_cycle();
    settle();
    check("post_rst_occ", 32'(bus.occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
